sad_best_sel: RTL and testbench
===============================

# sad_best_sel

Consumer of the SAD calculator result stream. It takes one `sad`/`sad_vld` result per candidate position over a rectangular search window, scanned in raster order. It tracks the minimum SAD and the (x, y) index of the candidate that produced it, then reports the winner with a one-cycle `done` pulse. It sits directly downstream of `top` (the SAD datapath) in the motion-search chain.

## Interface
- `DATA_BITS`, 8: pixel width used by the SAD datapath.
- `SAD_BITS`, `DATA_BITS+8`: width of one 16x16 SAD result.
- `SR_W`, 16: candidates per search-window row (≥2).
- `SR_H`, 16: candidate rows per search window (≥2).
- `XW`, `$clog2(SR_W)`: width of the x index.
- `YW`, `$clog2(SR_H)`: width of the y index.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that opens a new search window.
- `abort` in 1: cancels the window in progress.
- `sad` in `SAD_BITS`: candidate SAD from the datapath.
- `sad_vld` in 1: `sad` is valid this cycle.
- `busy` out 1: high while a window is being accumulated.
- `done` out 1: one-cycle pulse; `best_*` are final.
- `best_sad` out `SAD_BITS`: minimum SAD of the last completed window.
- `best_x` out `XW`: column index of the winning candidate.
- `best_y` out `YW`: row index of the winning candidate.
- `err_stray` out 1: sticky; `sad_vld` was seen while not busy.

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE → ACC on `start`.
  - Clear `cx`/`cy` to 0.
  - Load the running minimum with all-ones.
  - Clear `err_stray`.
- ACC, on each `sad_vld`:
  - Compare `sad` with the running minimum (unsigned).
  - Replace the minimum only if strictly less. On a tie the earliest candidate in raster order wins.
  - On replace, capture the current `cx`, `cy` as the winning index.
  - Advance the index: `cx` increments; at `SR_W-1` it wraps to 0 and `cy` increments.
- ACC → DONE when the candidate at (`SR_W-1`, `SR_H-1`) is accepted. `cx`, `cy` do not wrap past this point.
- DONE, for one cycle:
  - `done`=1.
  - `best_sad`/`best_x`/`best_y` are loaded from the running registers at the ACC→DONE edge and held until the next completed window.
  - Next state is IDLE. If `start`=1 in DONE, go directly to ACC (back-to-back windows).
- `abort` in ACC → IDLE:
  - No `done`.
  - `best_*` keep their previous values.
  - A simultaneous `sad_vld` is discarded; abort wins.
- `start` while in ACC is ignored.
- `abort` outside ACC is ignored.
- `sad_vld` in IDLE or DONE: the data is ignored and `err_stray` is set. `err_stray` is cleared only by `rst` or by an accepted `start`.
- `busy` = (state == ACC).
- Width rules:
  - The compare is unsigned `SAD_BITS` wide.
  - An all-ones `sad` never beats the initial all-ones minimum. In that case the winner stays at index (0,0) with `best_sad` = all-ones.

## Timing
- Reset values:
  - state IDLE.
  - `busy`=0, `done`=0, `err_stray`=0.
  - `best_sad`=all-ones, `best_x`=0, `best_y`=0.
  - `cx`=`cy`=0.
- `start` sampled at edge N → `busy`=1 from N+1. The first `sad_vld` may arrive in cycle N+1.
- The last `sad_vld` sampled at edge M → at M+1:
  - `done`=1.
  - `best_*` valid.
  - `busy`=0.
- Total latency from the last result to the winner is 1 cycle.
- `sad_vld` may be high every cycle or have gaps of any length. There is no backpressure; every result in ACC is consumed.
- A full window takes exactly `SR_W*SR_H` accepted results.
- `rst` mid-window: back to IDLE on the next edge, all outputs at reset values, no `done`.

## Structure
- Shared package `sad_pkg`:
  - `DATA_BITS` and `SAD_BITS` defaults (shared with the SAD datapath).
  - State enum `{S_IDLE, S_ACC, S_DONE}`.
  - Constant `SAD_MAX` (all-ones).
- Sub-module `sad_raster_cnt`:
  - x/y raster counter with `clr`, `inc`, and a `last` flag at (`SR_W-1`, `SR_H-1`).
  - Reused later by the candidate-fetch side that drives `cal_en`.
- Compare/update and the FSM stay in `sad_best_sel`.

## Test plan
- Ramp, SR_W=SR_H=4: `start`, then 16 contiguous `sad_vld` with `sad` = 100−k (k=0..15) → `done` one cycle after the 16th, `best_sad`=85, `best_x`=3, `best_y`=3.
- Tie: all 16 `sad`=0x0040 except k=5 and k=9, both =0x0010 → `best_sad`=0x0010, `best_x`=1, `best_y`=1 (earliest winner).
- Gapped input: 16 results with random 0–5 idle cycles between them, minimum 7 at k=12 → `busy` high throughout, `done` exactly once, `best`=(0,3), sad=7.
- Abort: an earlier window completes with `best_sad`=20. In the next window, `abort` coincides with the 8th `sad_vld` (sad=0) → no `done`, `best_sad` still 20, `busy` low next cycle.
- Stray and back-to-back:
  - `sad_vld` in IDLE → `err_stray`=1.
  - `start` clears it.
  - `start` asserted in the DONE cycle → `busy`=1 on the next cycle with no IDLE gap; both windows report correct minima.
- Reset mid-window: `rst` after 6 results → next cycle all outputs at reset values; a subsequent full window reports the correct result.

Source files
------------

// File: rtl/sad_pkg.sv
// sad_pkg: definitions shared by the SAD datapath and its consumers.
//   DATA_BITS_DEF / SAD_BITS_DEF : default pixel and SAD result widths
//   state_t                      : FSM states of the best-candidate selector
//   SAD_MAX                      : all-ones SAD at the default width
package sad_pkg;

  localparam int DATA_BITS_DEF = 8;
  // A 16x16 block sums 256 absolute differences, which adds 8 bits.
  localparam int SAD_BITS_DEF  = DATA_BITS_DEF + 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [SAD_BITS_DEF-1:0] SAD_MAX = '1;

endpackage : sad_pkg

// File: rtl/sad_raster_cnt.sv
// sad_raster_cnt: x/y raster-order position counter over an SR_W x SR_H grid.
//   clk, rst : clock, synchronous active-high reset
//   clr      : return to (0,0); has priority over inc
//   inc      : advance one position (x first, then y)
//   cx, cy   : current position
//   last     : current position is (SR_W-1, SR_H-1)
// The counter holds at the last position instead of wrapping, so a stray
// extra increment cannot alias onto (0,0).
module sad_raster_cnt #(
  parameter int SR_W = 16,
  parameter int SR_H = 16,
  parameter int XW   = $clog2(SR_W),
  parameter int YW   = $clog2(SR_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          last
);

  logic x_end;
  logic y_end;

  assign x_end = (cx == XW'(SR_W - 1));
  assign y_end = (cy == YW'(SR_H - 1));
  assign last  = x_end && y_end;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cx <= '0;
      cy <= '0;
    end else if (inc && !last) begin
      if (x_end) begin
        cx <= '0;
        cy <= cy + YW'(1);
      end else begin
        cx <= cx + XW'(1);
      end
    end
  end

endmodule : sad_raster_cnt

// File: rtl/sad_best_sel.sv
// sad_best_sel: tracks the minimum SAD over one search window of SR_W x SR_H
// candidates delivered in raster order and reports the winner.
//   clk, rst  : clock, synchronous active-high reset
//   start     : pulse opening a new window (accepted in IDLE and DONE)
//   abort     : cancel the window in progress (ACC only)
//   sad       : candidate SAD, qualified by sad_vld
//   busy      : window being accumulated
//   done      : one-cycle pulse, best_* just updated
//   best_sad  : minimum SAD of the last completed window
//   best_x/y  : raster index of the winning candidate
//   err_stray : sticky, sad_vld seen outside ACC; cleared by rst or start
module sad_best_sel
  import sad_pkg::*;
#(
  parameter int DATA_BITS = sad_pkg::DATA_BITS_DEF,
  parameter int SAD_BITS  = DATA_BITS + 8,
  parameter int SR_W      = 16,
  parameter int SR_H      = 16,
  parameter int XW        = $clog2(SR_W),
  parameter int YW        = $clog2(SR_H)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [SAD_BITS-1:0] sad,
  input  logic                sad_vld,
  output logic                busy,
  output logic                done,
  output logic [SAD_BITS-1:0] best_sad,
  output logic [XW-1:0]       best_x,
  output logic [YW-1:0]       best_y,
  output logic                err_stray
);

  state_t state, state_nxt;

  logic [XW-1:0]       cx;
  logic [YW-1:0]       cy;
  logic                last;

  logic [SAD_BITS-1:0] run_min;
  logic [XW-1:0]       run_x;
  logic [YW-1:0]       run_y;

  logic                start_acc;   // start that actually opens a window
  logic                accept;      // candidate consumed this cycle
  logic                better;      // strictly less: ties keep the earlier one
  logic [SAD_BITS-1:0] upd_min;
  logic [XW-1:0]       upd_x;
  logic [YW-1:0]       upd_y;

  assign start_acc = start && (state == S_IDLE || state == S_DONE);
  // Abort wins over a simultaneous result.
  assign accept    = (state == S_ACC) && sad_vld && !abort;
  assign better    = sad < run_min;

  // Running minimum including the candidate accepted this cycle; used both
  // to update the running registers and to load best_* on the final one.
  assign upd_min = (accept && better) ? sad : run_min;
  assign upd_x   = (accept && better) ? cx  : run_x;
  assign upd_y   = (accept && better) ? cy  : run_y;

  assign busy = (state == S_ACC);
  assign done = (state == S_DONE);

  sad_raster_cnt #(
    .SR_W (SR_W),
    .SR_H (SR_H),
    .XW   (XW),
    .YW   (YW)
  ) u_raster_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .inc  (accept),
    .cx   (cx),
    .cy   (cy),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt takes its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_ACC;
      S_ACC: begin
        if (abort)               state_nxt = S_IDLE;
        else if (accept && last) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = start ? S_ACC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Running minimum. All-ones start value means an all-ones SAD never wins,
  // leaving the winner at (0,0).
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      run_min <= '1;
      run_x   <= '0;
      run_y   <= '0;
    end else begin
      run_min <= upd_min;
      run_x   <= upd_x;
      run_y   <= upd_y;
    end
  end

  // Reported winner changes only when a window completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_sad <= '1;
      best_x   <= '0;
      best_y   <= '0;
    end else if (accept && last) begin
      best_sad <= upd_min;
      best_x   <= upd_x;
      best_y   <= upd_y;
    end
  end

  // A stray result in the same cycle as start still flags, so the error
  // is never lost.
  always_ff @(posedge clk) begin
    if (rst)                            err_stray <= 1'b0;
    else if (sad_vld && state != S_ACC) err_stray <= 1'b1;
    else if (start_acc)                 err_stray <= 1'b0;
  end

endmodule : sad_best_sel

// File: tb/tb_sad_best_sel.sv
// tb_sad_best_sel: directed test of sad_best_sel on a 4x4 search window.
module tb_sad_best_sel;

  localparam int SR_W  = 4;
  localparam int SR_H  = 4;
  localparam int XW    = 2;
  localparam int YW    = 2;
  localparam int SB    = 16;
  localparam int NCAND = SR_W * SR_H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [SB-1:0] sad = '0;
  logic          sad_vld = 1'b0;
  logic          busy;
  logic          done;
  logic [SB-1:0] best_sad;
  logic [XW-1:0] best_x;
  logic [YW-1:0] best_y;
  logic          err_stray;

  int total = 0;
  int bad   = 0;
  int vals [NCAND];

  sad_best_sel #(
    .DATA_BITS (8),
    .SR_W      (SR_W),
    .SR_H      (SR_H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .sad       (sad),
    .sad_vld   (sad_vld),
    .busy      (busy),
    .done      (done),
    .best_sad  (best_sad),
    .best_x    (best_x),
    .best_y    (best_y),
    .err_stray (err_stray)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int base, input int step);
    for (int k = 0; k < NCAND; k++) vals[k] = base + step * k;
  endtask

  task automatic open_win();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    check("stray_clr_by_start", 32'(err_stray), 0);
  endtask

  // Feed n candidates from vals[]; done must rise only after the final one.
  task automatic feed(input int n, input int gap_max);
    for (int k = 0; k < n; k++) begin
      int gap;
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int g = 0; g < gap; g++) begin
        tick();
        check("gap_busy", 32'(busy), 1);
        check("gap_no_done", 32'(done), 0);
      end
      sad     = SB'(vals[k]);
      sad_vld = 1'b1;
      tick();
      sad_vld = 1'b0;
      check($sformatf("done_k%0d", k), 32'(done), (k == NCAND - 1) ? 1 : 0);
      check($sformatf("busy_k%0d", k), 32'(busy), (k == NCAND - 1) ? 0 : 1);
    end
  endtask

  task automatic check_best(input string tag, input int s, input int x, input int y);
    check({tag, "_sad"}, 32'(best_sad), 32'(s));
    check({tag, "_x"},   32'(best_x),   32'(x));
    check({tag, "_y"},   32'(best_y),   32'(y));
  endtask

  initial begin
    tick();
    tick();
    check_best("reset", 'hFFFF, 0, 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_stray", 32'(err_stray), 0);
    rst = 1'b0;
    tick();

    // Ramp 100-k: last candidate is the minimum.
    fill(100, -1);
    open_win();
    feed(NCAND, 0);
    check_best("ramp", 85, 3, 3);
    tick();
    check("ramp_done_pulse", 32'(done), 0);

    // Tie: k=5 (1,1) and k=9 (1,2) equal; the earlier wins.
    fill('h40, 0);
    vals[5] = 'h10;
    vals[9] = 'h10;
    open_win();
    feed(NCAND, 0);
    check_best("tie", 'h10, 1, 1);
    tick();

    // Gapped input, minimum 7 at k=12 -> (0,3).
    fill(50, 1);
    vals[12] = 7;
    open_win();
    feed(NCAND, 5);
    check_best("gap", 7, 0, 3);
    tick();

    // All-ones candidates never beat the initial minimum.
    fill('hFFFF, 0);
    open_win();
    feed(NCAND, 0);
    check_best("allones", 'hFFFF, 0, 0);
    tick();

    // Window with best 20 at k=6 -> (2,1), then an aborted window.
    fill(30, 1);
    vals[6] = 20;
    open_win();
    feed(NCAND, 0);
    check_best("pre_abort", 20, 2, 1);
    tick();
    fill(10, 0);
    open_win();
    feed(7, 0);
    sad     = '0;
    sad_vld = 1'b1;
    abort   = 1'b1;
    tick();
    sad_vld = 1'b0;
    abort   = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check_best("abort", 20, 2, 1);
    tick();
    check("abort_no_late_done", 32'(done), 0);

    // Stray result in IDLE sets the sticky flag; start clears it.
    sad     = 16'd1;
    sad_vld = 1'b1;
    tick();
    sad_vld = 1'b0;
    check("stray_set", 32'(err_stray), 1);
    check("stray_idle_busy", 32'(busy), 0);
    tick();
    check("stray_sticky", 32'(err_stray), 1);

    // Back-to-back: A min 11 at k=10 (2,2); start in DONE; B min 5 at k=3 (3,0).
    fill(60, 0);
    vals[10] = 11;
    open_win();
    feed(NCAND, 0);
    check_best("b2b_a", 11, 2, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", 32'(busy), 1);
    check("b2b_done_low", 32'(done), 0);
    fill(90, 0);
    vals[3] = 5;
    feed(NCAND, 0);
    check_best("b2b_b", 5, 3, 0);
    tick();

    // Stray while in DONE also flags.
    fill(70, 0);
    open_win();
    feed(NCAND, 0);
    sad_vld = 1'b1;
    tick();
    sad_vld = 1'b0;
    check("stray_in_done", 32'(err_stray), 1);

    // Reset mid-window, then a clean window.
    fill(40, 0);
    open_win();
    feed(6, 0);
    rst = 1'b1;
    tick();
    check_best("midrst", 'hFFFF, 0, 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_stray", 32'(err_stray), 0);
    rst = 1'b0;
    tick();
    check("midrst_no_done", 32'(done), 0);
    fill(100, -1);
    vals[7] = 3;
    open_win();
    feed(NCAND, 0);
    check_best("post_rst", 3, 3, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sad_best_sel
